hpdcache_sram_1rw_ctrl: RTL and testbench
=========================================

// Module: hpdcache_sram_1rw_ctrl
// PURPOSE
//  Sequencer and arbiter for one single-port (1RW) cache SRAM macro with a registered read port.
//  - Clears every SRAM entry to zero after reset and on flush.
//  - Then shares the single port between two requesters: port 0 (refill, high priority)
//    and port 1 (core access, starvation-protected).
//  - Returns read data one cycle after grant.
//  Sits between the miss/refill and core pipelines and the SRAM instance.
// PARAMETERS
//  ADDR_SIZE   6               SRAM address width
//  DATA_SIZE   64              SRAM word width
//  DEPTH       2**ADDR_SIZE    number of entries; need not be a power of two
//  MAX_STARVE  4               consecutive losing cycles of port 1 before it is forced to win; >=1
// PORTS
//  clk          in   1          clock; all logic on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  flush        in   1          pulse: re-clear whole SRAM
//  init_done    out  1          1 = clear finished, arbitration enabled
//  req0_valid   in   1          port 0 request valid
//  req0_ready   out  1          port 0 granted this cycle
//  req0_we      in   1          port 0: 1 = write, 0 = read
//  req0_addr    in   ADDR_SIZE  port 0 address
//  req0_wdata   in   DATA_SIZE  port 0 write data
//  req1_valid   in   1          port 1 request valid
//  req1_ready   out  1          port 1 granted this cycle
//  req1_we      in   1          port 1: 1 = write, 0 = read
//  req1_addr    in   ADDR_SIZE  port 1 address
//  req1_wdata   in   DATA_SIZE  port 1 write data
//  rsp0_valid   out  1          read data for port 0 on rsp_rdata
//  rsp1_valid   out  1          read data for port 1 on rsp_rdata
//  rsp_rdata    out  DATA_SIZE  read data; pass-through of sram_rdata
//  sram_cs      out  1          SRAM chip select
//  sram_we      out  1          SRAM write enable
//  sram_addr    out  ADDR_SIZE  SRAM address
//  sram_wdata   out  DATA_SIZE  SRAM write data
//  sram_rdata   in   DATA_SIZE  SRAM read data; registered, valid the cycle after cs&!we
// BEHAVIOUR
//  Reset values: state=INIT, init cnt=0, starve cnt=0, init_done=0, rsp*_valid=0.
//  Reset is async assert, sync deassert. Reset mid-clear or mid-read drops all progress.
//  FSM, 2 states:
//  - INIT
//    - sram_cs=1, sram_we=1, sram_wdata=0, sram_addr=cnt; cnt increments every cycle.
//    - req*_ready=0, init_done=0.
//    - cnt==DEPTH-1 -> ARB next cycle; cnt clears to 0. Clear takes exactly DEPTH cycles.
//  - ARB
//    - init_done=1.
//    - flush=1 -> INIT next cycle; no grant in that cycle.
//    - flush in INIT restarts cnt at 0.
//  Grant in ARB, combinational, no flush:
//  - Default: port 0 wins when req0_valid.
//  - Port 1 wins when !req0_valid or starve==MAX_STARVE.
//  - readyK=1 only for the winner. Its we/addr/wdata drive sram_*, sram_cs=1.
//  - sram_cs=0 when no grant; other sram_* are don't-care.
//  Starve counter:
//  - +1 when req1_valid & port 0 granted.
//  - Cleared when port 1 is granted or req1_valid=0.
//  - Saturates at MAX_STARVE.
//  Response:
//  - rspK_valid is registered = (readyK & !reqK_we) of the previous cycle.
//  - rsp_rdata = sram_rdata, combinational. Read latency is exactly 1 cycle.
//  - No response backpressure. A response due after a flush grant-cycle is still delivered.
//  - rspK_valid are never both 1. Writes produce no response.
//  Requesters may drop valid without a grant. Payload is sampled only in the grant cycle.
// TESTING
//  1. Release reset, DEPTH=64, no requests
//     -> cs=we=1 for addrs 0..63 on 64 consecutive cycles, wdata=0; init_done=1 on cycle 65.
//  2. After init: port 1 write addr 5 = 0xA5, then read addr 5
//     -> req1_ready each cycle; rsp1_valid=1, rsp_rdata=0xA5 one cycle after the read grant.
//  3. req0 and req1 valid continuously, MAX_STARVE=4
//     -> grants 0,0,0,0,1 repeating; never >4 consecutive port-1 losses.
//  4. flush pulsed in the cycle of a port-1 read grant request
//     -> no grant that cycle; INIT re-clears all 64 entries; a read of any address afterwards returns 0.
//  5. Port 0 read in the cycle before flush
//     -> rsp0_valid still asserted the next cycle with the correct data.
//  6. rst_n asserted mid-INIT at cnt=30
//     -> outputs go to reset values immediately; after release, clearing restarts at addr 0.

Source files
------------

// File: rtl/hpdcache_sram_1rw_ctrl.sv
// Single-port cache SRAM sequencer: zero-fills the array after reset/flush, then arbitrates
// refill (port 0, priority) against core (port 1, starvation-protected) accesses.
module hpdcache_sram_1rw_ctrl #(
    parameter int unsigned ADDR_SIZE  = 6,
    parameter int unsigned DATA_SIZE  = 64,
    parameter int unsigned DEPTH      = 2**ADDR_SIZE,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    output logic                 init_done,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_we,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [DATA_SIZE-1:0] req0_wdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_we,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [DATA_SIZE-1:0] req1_wdata,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [DATA_SIZE-1:0] rsp_rdata,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [DATA_SIZE-1:0] sram_wdata,
    input  logic [DATA_SIZE-1:0] sram_rdata
);

    localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR  = ADDR_SIZE'(DEPTH - 1);
    localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(MAX_STARVE);

    typedef enum logic [0:0] {StInit, StArb} state_e;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 rsp0_q, rsp1_q;
    logic                 grant0, grant1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        init_done  = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = cnt_q;
        sram_wdata = '0;

        unique case (state_q)
            StInit: begin
                sram_cs = 1'b1;
                sram_we = 1'b1;
                if (flush) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = StArb;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StArb: begin
                init_done = 1'b1;
                if (flush) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end else begin
                    grant1 = req1_valid && (!req0_valid || starve_q == STARVE_MAX);
                    grant0 = req0_valid && !grant1;
                    if (grant0) begin
                        sram_cs    = 1'b1;
                        sram_we    = req0_we;
                        sram_addr  = req0_addr;
                        sram_wdata = req0_wdata;
                    end else if (grant1) begin
                        sram_cs    = 1'b1;
                        sram_we    = req1_we;
                        sram_addr  = req1_addr;
                        sram_wdata = req1_wdata;
                    end
                    // A waiting port 1 that is not granted implies port 0 won this cycle
                    if (grant1 || !req1_valid) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp_rdata  = sram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            starve_q <= '0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            rsp0_q   <= grant0 & ~req0_we;
            rsp1_q   <= grant1 & ~req1_we;
        end
    end

endmodule

// File: tb/tb_hpdcache_sram_1rw_ctrl.sv
// Directed bench for hpdcache_sram_1rw_ctrl with a behavioural registered-read SRAM model.
module tb_hpdcache_sram_1rw_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          init_done;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic [DW-1:0] mem [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    hpdcache_sram_1rw_ctrl #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .DEPTH     (DEPTH),
        .MAX_STARVE(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .init_done (init_done),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_we   (req0_we),
        .req0_addr (req0_addr),
        .req0_wdata(req0_wdata),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_we   (req1_we),
        .req1_addr (req1_addr),
        .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid),
        .rsp_rdata (rsp_rdata),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    typedef struct {
        logic          r0v;
        logic          r0we;
        logic [AW-1:0] r0addr;
        logic [DW-1:0] r0wdata;
        logic          r1v;
        logic          r1we;
        logic [AW-1:0] r1addr;
        logic [DW-1:0] r1wdata;
        logic          e_r0rdy;
        logic          e_r1rdy;
        logic          e_cs;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic          e_rsp0;
        logic          e_rsp1;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic r0v, input logic r0we, input logic [AW-1:0] r0a,
                         input logic [DW-1:0] r0d, input logic r1v, input logic r1we,
                         input logic [AW-1:0] r1a, input logic [DW-1:0] r1d);
        @(negedge clk);
        flush      = f;
        req0_valid = r0v;
        req0_we    = r0we;
        req0_addr  = r0a;
        req0_wdata = r0d;
        req1_valid = r1v;
        req1_we    = r1we;
        req1_addr  = r1a;
        req1_wdata = r1d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Caller has already positioned the bench in the first clear cycle
    task automatic check_clear(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) idle();
            chk($sformatf("%s clr%0d cs", tag, i), DW'(sram_cs), 1);
            chk($sformatf("%s clr%0d we", tag, i), DW'(sram_we), 1);
            chk($sformatf("%s clr%0d addr", tag, i), DW'(sram_addr), DW'(i));
            chk($sformatf("%s clr%0d wdata", tag, i), sram_wdata, 0);
            chk($sformatf("%s clr%0d init_done", tag, i), DW'(init_done), 0);
        end
        idle();
        chk({tag, " init_done after clear"}, DW'(init_done), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

        //         r0v  r0we r0a    r0d      r1v  r1we r1a    r1d      rdy0 rdy1 cs   we   addr   rsp0 rsp1 rdata
        vecs[0] = '{1'b0,1'b0,6'd0, 64'h0,  1'b1,1'b1,6'd5, 64'hA5, 1'b0,1'b1,1'b1,1'b1,6'd5, 1'b0,1'b0,64'h0};
        vecs[1] = '{1'b0,1'b0,6'd0, 64'h0,  1'b1,1'b0,6'd5, 64'h0,  1'b0,1'b1,1'b1,1'b0,6'd5, 1'b0,1'b0,64'h0};
        vecs[2] = '{1'b0,1'b0,6'd0, 64'h0,  1'b0,1'b0,6'd0, 64'h0,  1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,1'b1,64'hA5};
        vecs[3] = '{1'b1,1'b1,6'd7, 64'h77, 1'b1,1'b1,6'd9, 64'h99, 1'b1,1'b0,1'b1,1'b1,6'd7, 1'b0,1'b0,64'h0};
        vecs[4] = '{1'b1,1'b0,6'd7, 64'h0,  1'b1,1'b0,6'd9, 64'h0,  1'b1,1'b0,1'b1,1'b0,6'd7, 1'b0,1'b0,64'h0};
        vecs[5] = '{1'b0,1'b0,6'd0, 64'h0,  1'b1,1'b0,6'd9, 64'h0,  1'b0,1'b1,1'b1,1'b0,6'd9, 1'b1,1'b0,64'h77};
        vecs[6] = '{1'b0,1'b0,6'd0, 64'h0,  1'b0,1'b0,6'd0, 64'h0,  1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,1'b1,64'h0};
        vecs[7] = '{1'b1,1'b0,6'd5, 64'h0,  1'b0,1'b0,6'd0, 64'h0,  1'b1,1'b0,1'b1,1'b0,6'd5, 1'b0,1'b0,64'h0};
        vecs[8] = '{1'b0,1'b0,6'd0, 64'h0,  1'b0,1'b0,6'd0, 64'h0,  1'b0,1'b0,1'b0,1'b0,6'd0, 1'b1,1'b0,64'hA5};

        // Reset values while reset is held
        #1;
        chk("rst init_done", DW'(init_done), 0);
        chk("rst rsp0", DW'(rsp0_valid), 0);
        chk("rst rsp1", DW'(rsp1_valid), 0);
        chk("rst ready", DW'({req0_ready, req1_ready}), 0);
        chk("rst addr", DW'(sram_addr), 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_clear("init");

        for (int i = 0; i < 9; i++) begin
            drive(1'b0, vecs[i].r0v, vecs[i].r0we, vecs[i].r0addr, vecs[i].r0wdata,
                  vecs[i].r1v, vecs[i].r1we, vecs[i].r1addr, vecs[i].r1wdata);
            chk($sformatf("vec%0d ready0", i), DW'(req0_ready), DW'(vecs[i].e_r0rdy));
            chk($sformatf("vec%0d ready1", i), DW'(req1_ready), DW'(vecs[i].e_r1rdy));
            chk($sformatf("vec%0d cs", i), DW'(sram_cs), DW'(vecs[i].e_cs));
            if (vecs[i].e_cs) begin
                chk($sformatf("vec%0d we", i), DW'(sram_we), DW'(vecs[i].e_we));
                chk($sformatf("vec%0d addr", i), DW'(sram_addr), DW'(vecs[i].e_addr));
                if (vecs[i].e_we)
                    chk($sformatf("vec%0d wdata", i), sram_wdata,
                        vecs[i].e_r0rdy ? vecs[i].r0wdata : vecs[i].r1wdata);
            end
            chk($sformatf("vec%0d rsp0", i), DW'(rsp0_valid), DW'(vecs[i].e_rsp0));
            chk($sformatf("vec%0d rsp1", i), DW'(rsp1_valid), DW'(vecs[i].e_rsp1));
            if (vecs[i].e_rsp0 || vecs[i].e_rsp1)
                chk($sformatf("vec%0d rdata", i), rsp_rdata, vecs[i].e_rdata);
        end

        // Both ports busy: port 1 wins every fifth cycle
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 1'b1, 1'b1, 6'd1, 64'h1, 1'b1, 1'b1, 6'd2, 64'h2);
            chk($sformatf("starve%0d ready0", k), DW'(req0_ready), DW'(k % 5 != 4));
            chk($sformatf("starve%0d ready1", k), DW'(req1_ready), DW'(k % 5 == 4));
            chk($sformatf("starve%0d addr", k), DW'(sram_addr), (k % 5 == 4) ? 2 : 1);
        end
        idle();

        // Port 0 read then flush while port 1 asks: response survives, no grant in flush cycle
        drive(1'b0, 1'b1, 1'b0, 6'd1, 64'h0, 1'b0, 1'b0, 6'd0, 64'h0);
        chk("pre-flush ready0", DW'(req0_ready), 1);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0, 6'd2, 64'h0);
        chk("flush ready", DW'({req0_ready, req1_ready}), 0);
        chk("flush cs", DW'(sram_cs), 0);
        chk("flush rsp0", DW'(rsp0_valid), 1);
        chk("flush rdata", rsp_rdata, 64'h1);

        // Flush in the middle of clearing restarts from address 0
        for (int i = 0; i <= 10; i++) begin
            drive(i == 10, 1'b0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0, 6'd2, 64'h0);
            chk($sformatf("reflush%0d addr", i), DW'(sram_addr), DW'(i));
            chk($sformatf("reflush%0d ready1", i), DW'(req1_ready), 0);
        end
        idle();
        check_clear("flush");

        drive(1'b0, 1'b0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0, 6'd2, 64'h0);
        chk("post-flush ready1", DW'(req1_ready), 1);
        drive(1'b0, 1'b1, 1'b0, 6'd5, 64'h0, 1'b1, 1'b0, 6'd63, 64'h0);
        chk("post-flush rsp1 a2", DW'(rsp1_valid), 1);
        chk("post-flush rdata a2", rsp_rdata, 0);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0, 6'd63, 64'h0);
        chk("post-flush rsp0 a5", DW'(rsp0_valid), 1);
        chk("post-flush rdata a5", rsp_rdata, 0);
        idle();
        chk("post-flush rsp1 a63", DW'(rsp1_valid), 1);
        chk("post-flush rdata a63", rsp_rdata, 0);

        // Asynchronous reset drops a pending response and a partial clear
        drive(1'b0, 1'b1, 1'b1, 6'd5, 64'h5A, 1'b0, 1'b0, 6'd0, 64'h0);
        drive(1'b0, 1'b1, 1'b0, 6'd5, 64'h0, 1'b0, 1'b0, 6'd0, 64'h0);
        idle();
        chk("pre-rst rsp0", DW'(rsp0_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst rsp0", DW'(rsp0_valid), 0);
        chk("async rst init_done", DW'(init_done), 0);
        chk("async rst addr", DW'(sram_addr), 0);
        idle();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) idle();
            chk($sformatf("midrst%0d addr", i), DW'(sram_addr), DW'(i));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst addr reset", DW'(sram_addr), 0);
        chk("midrst init_done", DW'(init_done), 0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_clear("rst");
        drive(1'b0, 1'b0, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0, 6'd5, 64'h0);
        idle();
        chk("final rsp1", DW'(rsp1_valid), 1);
        chk("final rdata", rsp_rdata, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
